// File: rtl/mux_pkg.sv
// mux_pkg: shared select-code type and constants for the 3:1 mux family
package mux_pkg;
  typedef logic [1:0] sel_t;
  localparam sel_t SEL_IN0 = 2'd0;
  localparam sel_t SEL_IN1 = 2'd1;
  localparam sel_t SEL_IN2 = 2'd2;
  localparam sel_t SEL_BAD = 2'd3;
endpackage

// File: rtl/mux_3to1_comb.sv
// mux_3to1_comb: combinational 3:1 select with illegal-code indication
module mux_3to1_comb
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] in_0,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic [1:0]       ctrl,
  output logic [WIDTH-1:0] sel_data,
  output logic             bad_sel
);
  always_comb begin
    bad_sel  = ctrl == SEL_BAD;
    sel_data = ctrl == SEL_IN0 ? in_0 :
               ctrl == SEL_IN1 ? in_1 :
               ctrl == SEL_IN2 ? in_2 : '0;
  end
endmodule

// File: rtl/mux_3to1_reg.sv
// mux_3to1_reg: registered 3:1 mux with registered illegal-select flag
module mux_3to1_reg
  import mux_pkg::*;
#(
  parameter int WIDTH        = 1,
  parameter int BAD_SEL_HOLD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_0,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic [1:0]       ctrl,
  output logic [WIDTH-1:0] out,
  output logic             sel_err
);
  logic [WIDTH-1:0] sel_data;
  logic             bad_sel;
  mux_3to1_comb #(.WIDTH(WIDTH)) u_comb (
    .in_0     (in_0),
    .in_1     (in_1),
    .in_2     (in_2),
    .ctrl     (ctrl),
    .sel_data (sel_data),
    .bad_sel  (bad_sel)
  );
  // the comb stage already yields zero on a bad code, so only hold mode needs gating
  always_ff @(posedge clk) begin
    if (rst) begin
      out     <= '0;
      sel_err <= 1'b0;
    end else begin
      sel_err <= bad_sel;
      if (!bad_sel || BAD_SEL_HOLD == 0) out <= sel_data;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) assert (!$isunknown(ctrl));
  end
endmodule

// File: tb/tb_mux_3to1_reg.sv
// tb_mux_3to1_reg: directed and random checks of three mux_3to1_reg configurations
module tb_mux_3to1_reg;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_0, in_1, in_2;
  logic [1:0] ctrl;
  logic [0:0] w1_out;
  logic [7:0] h0_out, h1_out;
  logic       w1_err, h0_err, h1_err;
  logic [7:0] m_w1, m_h0, m_h1;
  logic       m_err;
  int         checks = 0;
  int         errors = 0;
  always #5 clk = ~clk;
  mux_3to1_reg #(.WIDTH(1), .BAD_SEL_HOLD(0)) dut_w1 (
    .clk(clk), .rst(rst), .in_0(in_0[0]), .in_1(in_1[0]), .in_2(in_2[0]),
    .ctrl(ctrl), .out(w1_out), .sel_err(w1_err)
  );
  mux_3to1_reg #(.WIDTH(8), .BAD_SEL_HOLD(0)) dut_h0 (
    .clk(clk), .rst(rst), .in_0(in_0), .in_1(in_1), .in_2(in_2),
    .ctrl(ctrl), .out(h0_out), .sel_err(h0_err)
  );
  mux_3to1_reg #(.WIDTH(8), .BAD_SEL_HOLD(1)) dut_h1 (
    .clk(clk), .rst(rst), .in_0(in_0), .in_1(in_1), .in_2(in_2),
    .ctrl(ctrl), .out(h1_out), .sel_err(h1_err)
  );
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, " w1.out"}, {7'd0, w1_out}, m_w1);
    chk({tag, " h0.out"}, h0_out, m_h0);
    chk({tag, " h1.out"}, h1_out, m_h1);
    chk({tag, " w1.err"}, {7'd0, w1_err}, {7'd0, m_err});
    chk({tag, " h0.err"}, {7'd0, h0_err}, {7'd0, m_err});
    chk({tag, " h1.err"}, {7'd0, h1_err}, {7'd0, m_err});
  endtask
  task automatic step(input string tag, input logic r, input logic [1:0] c,
                      input logic [7:0] a, input logic [7:0] b, input logic [7:0] d);
    logic [7:0] src [3];
    @(negedge clk);
    rst = r; ctrl = c; in_0 = a; in_1 = b; in_2 = d;
    @(posedge clk);
    src = '{a, b, d};
    if (r) begin
      m_w1 = 8'h00; m_h0 = 8'h00; m_h1 = 8'h00; m_err = 1'b0;
    end else if (c != 2'd3) begin
      m_w1 = src[c] & 8'h01; m_h0 = src[c]; m_h1 = src[c]; m_err = 1'b0;
    end else begin
      m_w1 = 8'h00; m_h0 = 8'h00; m_err = 1'b1;
    end
    #1 check_all(tag);
    in_0 = 8'($urandom); in_1 = 8'($urandom); in_2 = 8'($urandom);
    ctrl = 2'($urandom); rst = 1'($urandom);
    #2 check_all({tag, " mid"});
  endtask
  initial begin
    m_w1 = 8'h00; m_h0 = 8'h00; m_h1 = 8'h00; m_err = 1'b0;
    step("rst0", 1'b1, 2'd0, 8'h01, 8'h01, 8'h01);
    step("rst1", 1'b1, 2'd0, 8'h01, 8'h01, 8'h01);
    step("rel", 1'b0, 2'd0, 8'h01, 8'h01, 8'h01);
    step("sel0", 1'b0, 2'd0, 8'h01, 8'h00, 8'h00);
    step("sel1", 1'b0, 2'd1, 8'h00, 8'h01, 8'h00);
    step("sel2", 1'b0, 2'd2, 8'h01, 8'h01, 8'h00);
    for (int i = 0; i < 4; i++)
      step("iso", 1'b0, 2'd1, (i % 2 == 1) ? 8'hFF : 8'h00, 8'hA5, (i % 2 == 1) ? 8'h00 : 8'hFF);
    step("pre3c", 1'b0, 2'd0, 8'h3C, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++)
      step("bad", 1'b0, 2'd3, 8'h55, 8'h66, 8'h77);
    step("recover", 1'b0, 2'd2, 8'h00, 8'h00, 8'h11);
    step("rstbad", 1'b1, 2'd3, 8'h12, 8'h34, 8'h56);
    step("postrst", 1'b0, 2'd1, 8'h00, 8'h9E, 8'h00);
    for (int i = 0; i < 200; i++)
      step("rand", ($urandom_range(0, 15) == 0), 2'($urandom),
           8'($urandom), 8'($urandom), 8'($urandom));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
